// File: rtl/bht_predictor.sv
// Direct-mapped 2-bit BHT with tag/target; optional counters under BPRED_STATS_EN.
// Latency: lookup and mispredict are combinational, training lands on the next clk edge.
// Backpressure: none, one lookup and one update accepted every cycle.
module bht_predictor #(
    parameter int DATAW = 32,
    parameter int IDXW  = 6,
    parameter int TAGW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATAW-1:0] if_pc,
    output logic             pred_taken,
    output logic [DATAW-1:0] pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [DATAW-1:0] ex_pc,
    input  logic             ex_taken,
    input  logic [DATAW-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic [DATAW-1:0] ex_pred_target,
    output logic             mispredict,
    output logic [DATAW-1:0] redirect_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred
`endif
);

    localparam int N = 1 << IDXW;

    logic [N-1:0]     valid_q;
    logic [1:0]       ctr_q [N];
    logic [TAGW-1:0]  tag_q [N];
    logic [DATAW-1:0] tgt_q [N];

    logic [IDXW-1:0]  if_idx;
    logic [TAGW-1:0]  if_tag;
    logic [IDXW-1:0]  ex_idx;
    logic [TAGW-1:0]  ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             upd;

    assign if_idx = if_pc[IDXW+1:2];
    assign if_tag = if_pc[IDXW+TAGW+1:IDXW+2];
    assign ex_idx = ex_pc[IDXW+1:2];
    assign ex_tag = ex_pc[IDXW+TAGW+1:IDXW+2];

    // Low PC bits and bits above the tag never take part in the lookup.
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc[1:0], if_pc[DATAW-1:IDXW+TAGW+2]};

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd    = rst_n && ex_valid && ex_is_branch;

    assign pred_taken  = rst_n && if_hit && ctr_q[if_idx][1];
    assign pred_target = (rst_n && if_hit) ? tgt_q[if_idx] : '0;

    assign mispredict  = upd && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = !mispredict ? '0 :
                         ex_taken    ? ex_target : ex_pc + DATAW'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= 2'b00;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (ex_taken && ctr_q[ex_idx] != 2'b11) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                end else if (!ex_taken && ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx] <= 1'b1;
                ctr_q[ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target need no reset; a taken hit rewrites the same tag, which is harmless.
    always_ff @(posedge clk) begin
        if (upd && ex_taken) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_target;
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed vector table, hand sequences, and random traffic vs a model.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int n_vec = 0;
    int n_err = 0;

    bht_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BPRED_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: 64 entries, counter kept as an integer 0..3.
    bit          m_valid [64];
    int          m_tag   [64];
    int          m_ctr   [64];
    logic [31:0] m_tgt   [64];
    int          m_br, m_mp;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    function automatic bit m_mis();
        return rst_n && ex_valid && ex_is_branch &&
               (ex_taken != ex_pred_taken || (ex_taken && ex_pred_target != ex_target));
    endfunction

    task automatic model_update();
        int i;
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 0;
            end
            m_br = 0;
            m_mp = 0;
        end else if (ex_valid && ex_is_branch) begin
            m_br++;
            if (m_mis()) m_mp++;
            i = idx_of(ex_pc);
            if (m_hit(ex_pc)) begin
                m_ctr[i] = ex_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (ex_taken) m_tgt[i] = ex_target;
            end else if (ex_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(ex_pc);
                m_ctr[i]   = 2;
                m_tgt[i]   = ex_target;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic drive_ex(logic v, logic b, logic [31:0] pc, logic tk, logic [31:0] tg,
                            logic ptk, logic [31:0] ptg);
        ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = tk;
        ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic chk_model(string nm);
        bit h;
        h = rst_n && m_hit(if_pc);
        chk({nm, ".pred_taken"}, 32'(pred_taken), 32'(h && m_ctr[idx_of(if_pc)] >= 2));
        chk({nm, ".pred_target"}, pred_target, h ? m_tgt[idx_of(if_pc)] : 32'h0);
        chk({nm, ".mispredict"}, 32'(mispredict), 32'(m_mis()));
        chk({nm, ".redirect_pc"}, redirect_pc,
            !m_mis() ? 32'h0 : ex_taken ? ex_target : ex_pc + 32'd4);
    endtask

    typedef struct {
        logic [31:0] if_pc;
        logic        v, b;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
        logic        ptk;
        logic [31:0] ptg;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{32'h100, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0};
        vt[1]  = '{32'h100, 1, 1, 32'h100,      1, 32'h80, 0, 32'h0,  0, 32'h0,  1, 32'h80};
        vt[2]  = '{32'h100, 1, 1, 32'h100,      1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0};
        vt[3]  = '{32'h100, 1, 1, 32'h100,      1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0};
        vt[4]  = '{32'h100, 1, 1, 32'h100,      0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104};
        vt[5]  = '{32'h100, 1, 1, 32'h100,      0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104};
        vt[6]  = '{32'h100, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0, 32'h80, 0, 32'h0};
        vt[7]  = '{32'h100, 1, 1, 32'h200,      1, 32'h40, 0, 32'h0,  0, 32'h80, 1, 32'h40};
        vt[8]  = '{32'h100, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0};
        vt[9]  = '{32'h200, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, 32'h40, 0, 32'h0};
        vt[10] = '{32'h200, 1, 0, 32'h300,      1, 32'h10, 0, 32'h0,  1, 32'h40, 0, 32'h0};
        vt[11] = '{32'h300, 1, 1, 32'hFFFFFFFC, 0, 32'h0,  1, 32'h0,  0, 32'h0,  1, 32'h0};
        vt[12] = '{32'h300, 1, 1, 32'h200,      1, 32'h44, 1, 32'h40, 0, 32'h0,  1, 32'h44};
        vt[13] = '{32'h200, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, 32'h44, 0, 32'h0};
        vt[14] = '{32'h200, 0, 1, 32'h400,      1, 32'h8,  0, 32'h0,  1, 32'h44, 0, 32'h0};
        vt[15] = '{32'h200, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, 32'h44, 0, 32'h0};

        rst_n = 1'b0;
        if_pc = 32'h100;
        drive_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        #1;
        chk("rst.pred_taken", 32'(pred_taken), 32'h0);
        chk("rst.mispredict", 32'(mispredict), 32'h0);
        chk("rst.redirect_pc", redirect_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if_pc = vt[i].if_pc;
            drive_ex(vt[i].v, vt[i].b, vt[i].pc, vt[i].tk, vt[i].tg, vt[i].ptk, vt[i].ptg);
            #1;
            chk($sformatf("vec%0d.pred_taken", i), 32'(pred_taken), 32'(vt[i].e_pt));
            chk($sformatf("vec%0d.pred_target", i), pred_target, vt[i].e_ptg);
            chk($sformatf("vec%0d.mispredict", i), 32'(mispredict), 32'(vt[i].e_mis));
            chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vt[i].e_red);
            tick();
        end

        // Reset cycle ignores a pending update, then same-cycle lookup sees pre-update state.
        rst_n = 1'b0;
        if_pc = 32'h200;
        drive_ex(1, 1, 32'h200, 1, 32'h60, 0, 32'h0);
        #1;
        chk("rst2.pred_taken", 32'(pred_taken), 32'h0);
        chk("rst2.pred_target", pred_target, 32'h0);
        chk("rst2.mispredict", 32'(mispredict), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("same.pred_taken", 32'(pred_taken), 32'h0);
        chk("same.mispredict", 32'(mispredict), 32'h1);
        tick();
        drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("same_next.pred_taken", 32'(pred_taken), 32'h1);
        chk("same_next.pred_target", pred_target, 32'h60);

        // Reset mid-operation: the training presented with it is dropped and the table clears.
        rst_n = 1'b0;
        drive_ex(1, 1, 32'h204, 1, 32'h90, 0, 32'h0);
        tick();
        rst_n = 1'b1;
        drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("midrst.pred_taken", 32'(pred_taken), 32'h0);
        chk("midrst.pred_target", pred_target, 32'h0);
        if_pc = 32'h204;
        #1;
        chk("midrst204.pred_taken", 32'(pred_taken), 32'h0);
        tick();

`ifdef BPRED_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_ex(1, 1, 32'h100 + 32'(i) * 4, 1, 32'h500, (i >= 2), 32'h500);
            tick();
        end
        drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("stat.branches", stat_branches, 32'd5);
        chk("stat.mispred", stat_mispred, 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("stat_rst.branches", stat_branches, 32'd0);
        chk("stat_rst.mispred", stat_mispred, 32'd0);
`endif

        // Random traffic on a small PC pool so entries hit, alias and saturate.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pc_a, pc_b;
            int i;
            pc_a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            pc_b = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) pc_a |= $urandom & 32'hFFFF0000;
            rst_n = ($urandom_range(0, 99) != 0);
            if_pc = pc_a;
            i = idx_of(pc_b);
            drive_ex($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, pc_b,
                     $urandom_range(0, 1),
                     $urandom_range(0, 1) ? 32'(($urandom_range(1, 3)) * 64) : $urandom,
                     0, 32'h0);
            if ($urandom_range(0, 3) != 0) begin
                ex_pred_taken  = m_hit(pc_b) && m_ctr[i] >= 2;
                ex_pred_target = m_hit(pc_b) ? m_tgt[i] : 32'h0;
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = $urandom_range(0, 1) ? ex_target : $urandom;
            end
            #1;
            chk_model($sformatf("rnd%0d", c));
`ifdef BPRED_STATS_EN
            chk($sformatf("rnd%0d.stat_branches", c), stat_branches, 32'(m_br));
            chk($sformatf("rnd%0d.stat_mispred", c), stat_mispred, 32'(m_mp));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Fetch-side branch predictor; it is the producer end of the branch-taken decision that the execute-stage comparator resolves.
- Holds a direct-mapped table of 2-bit saturating counters plus target/tag per entry.
- IF stage reads a prediction each cycle. EX stage writes back the resolved outcome, gets a mispredict flag and a redirect PC, and the table is trained.

Parameters:
- DATAW, 32, PC and target width.
- IDXW, 6, table index width; 2^IDXW entries.
- TAGW, 8, tag width stored per entry.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, synchronous active-low reset.
- if_pc, input, DATAW, PC being fetched.
- pred_taken, output, 1, predicted taken for if_pc.
- pred_target, output, DATAW, predicted target for if_pc.
- ex_valid, input, 1, EX stage holds a valid instruction.
- ex_is_branch, input, 1, EX instruction is a conditional branch.
- ex_pc, input, DATAW, PC of EX instruction.
- ex_taken, input, 1, resolved outcome from the branch comparator.
- ex_target, input, DATAW, resolved branch target.
- ex_pred_taken, input, 1, prediction carried down the pipe with the instruction.
- ex_pred_target, input, DATAW, predicted target carried down the pipe.
- mispredict, output, 1, flush request.
- redirect_pc, output, DATAW, correct next PC when mispredict=1.

Behaviour:
- Field extraction:
  - index = pc[IDXW+1:2].
  - tag = pc[IDXW+TAGW+1:IDXW+2].
  - pc[1:0] is ignored.
- Each entry holds: valid (1), tag (TAGW), ctr (2), target (DATAW).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational from table registers):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = hit ? target : 0.
- Mispredict (combinational from EX inputs):
  - mispredict = ex_valid & ex_is_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, with wrap modulo 2^DATAW.
  - redirect_pc is 0 when mispredict=0.
- Update happens on the rising clk edge when ex_valid & ex_is_branch:
  - Hit: ctr increments on taken, saturating at 11; decrements on not-taken, saturating at 00. Target is overwritten with ex_target when taken.
  - Miss and taken: allocate or replace the entry. valid=1, tag=ex tag, ctr=10, target=ex_target.
  - Miss and not-taken: no change.
- Same-cycle lookup and update on the same index: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Non-branch or ex_valid=0: the table is unchanged and mispredict=0.
- Reset:
  - When rst_n=0 at a clk edge, all valid bits clear to 0 and all ctr fields clear to 00 in one cycle. Tag and target fields are don't-care.
  - While rst_n=0: pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0.
  - The table ignores EX updates presented during the reset cycle.
  - Reset asserted mid-operation discards any training in that cycle.
- No stall or ready handshake: the block accepts one update and serves one lookup every cycle.

Optional Feature:
- Macro: BPRED_STATS_EN.
- Defined: adds two 32-bit outputs.
  - stat_branches counts cycles with ex_valid & ex_is_branch.
  - stat_mispred counts cycles with mispredict=1.
  - Both wrap at 2^32 and clear to 0 on reset.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0; mispredict=0 with ex_valid=0.
- EX branch: ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 → same cycle mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80 (ctr=10).
- Train 0x100: taken twice (ctr 11), then not-taken twice → ctr 01, pred_taken=0. Second not-taken with ex_pred_taken=1 → mispredict=1, redirect_pc=0x104.
- Aliasing: 0x100 trained taken, then EX taken branch at 0x100+(1<<(IDXW+2)) with target 0x40 → entry replaced. Lookup at 0x100 then misses (pred_taken=0).
- Same-cycle: if_pc=ex_pc=0x200, first taken update → pred_taken=0 that cycle, 1 the next.
- With BPRED_STATS_EN: 5 branches, 2 mispredicted → stat_branches=5, stat_mispred=2. rst_n=0 for one cycle → both 0 and the table is cleared.
